// File: rtl/demux1to2_stream.sv
// 1:2 stream demultiplexer: routes whole packets from one valid/ready input to one of two
// output channels, each buffered by a 2-entry FIFO so the consumers can stall independently.

module demux1to2_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);

  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic [W-1:0] head_nxt_s;
  logic [W-1:0] tail_nxt_s;
  logic [1:0]   count_r;
  logic [1:0]   count_nxt_s;
  logic         pop_s;

  assign pop_s = pop_ready & (count_r != 2'd0);
  assign head  = head_r;
  assign valid = (count_r != 2'd0);
  assign full  = (count_r == 2'd2);

  // Next head/tail/count; the head register always holds the oldest beat so outputs come straight from it.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    case (count_r)
      2'd0: begin
        if (push) begin
          head_nxt_s  = push_data;
          count_nxt_s = 2'd1;
        end else begin
          count_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop_s) begin
          head_nxt_s  = push_data;
          count_nxt_s = 2'd1;
        end else if (push) begin
          tail_nxt_s  = push_data;
          count_nxt_s = 2'd2;
        end else if (pop_s) begin
          count_nxt_s = 2'd0;
        end else begin
          count_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_nxt_s = tail_r;
          if (push) begin
            tail_nxt_s  = push_data;
            count_nxt_s = 2'd2;
          end else begin
            count_nxt_s = 2'd1;
          end
        end else begin
          count_nxt_s = 2'd2;
        end
      end
      default: begin
        count_nxt_s = 2'd0;
      end
    endcase
  end

  // FIFO storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

endmodule

module demux1to2_stream #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  output logic              out0_last,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  output logic              out1_last,
  input  logic              out1_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              busy
);

  localparam int FW = DATA_W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            route_r;
  logic            route_nxt_s;
  logic            target_s;
  logic            accept_s;
  logic            push0_s;
  logic            push1_s;
  logic            full0_s;
  logic            full1_s;
  logic [FW-1:0]   head0_s;
  logic [FW-1:0]   head1_s;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // The first beat of a packet follows in_sel; later beats follow the latched route.
  assign target_s = (state_r == IDLE) ? in_sel : route_r;
  assign in_ready = target_s ? ~full1_s : ~full0_s;
  assign accept_s = in_valid & in_ready;
  assign push0_s  = accept_s & ~target_s;
  assign push1_s  = accept_s & target_s;

  demux1to2_fifo2 #(.W(FW)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0_s),
    .push_data ({in_last, in_data}),
    .pop_ready (out0_ready),
    .head      (head0_s),
    .valid     (out0_valid),
    .full      (full0_s)
  );

  demux1to2_fifo2 #(.W(FW)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1_s),
    .push_data ({in_last, in_data}),
    .pop_ready (out1_ready),
    .head      (head1_s),
    .valid     (out1_valid),
    .full      (full1_s)
  );

  assign out0_data = head0_s[DATA_W-1:0];
  assign out0_last = head0_s[DATA_W];
  assign out1_data = head1_s[DATA_W-1:0];
  assign out1_last = head1_s[DATA_W];

  // Packet FSM: a multi-beat packet locks the route until its last beat is accepted.
  always_comb begin
    state_nxt_s = state_r;
    route_nxt_s = route_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !in_last) begin
          state_nxt_s = ROUTE;
          route_nxt_s = in_sel;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ROUTE: begin
        if (accept_s && in_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ROUTE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state and route register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      route_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      route_r <= route_nxt_s;
    end
  end

  // Per-channel accepted-beat counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else begin
      if (push0_s) begin
        cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (push1_s) begin
        cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
  assign busy = (state_r == ROUTE);

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream with per-channel scoreboard queues.

module tb_demux1to2_stream;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_sel;
  logic        in_ready;
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_last;
  logic        out0_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_last;
  logic        out1_ready;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        mid_m = 1'b0;
  logic        route_m = 1'b0;

  demux1to2_stream #(.DATA_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_last  (out0_last),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_last  (out1_last),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard push: beats the bench sees handshaken go to the queue of the modelled target.
  always @(negedge clk) begin
    logic tgt;
    if (rst_n && in_valid && in_ready) begin
      tgt = mid_m ? route_m : in_sel;
      if (tgt) q1.push_back({in_last, in_data});
      else     q0.push_back({in_last, in_data});
      if (!mid_m) begin
        if (!in_last) begin
          mid_m   = 1'b1;
          route_m = in_sel;
        end
      end else if (in_last) begin
        mid_m = 1'b0;
      end
    end
  end

  // Scoreboard pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        check("sb0_nonempty", (q0.size() != 0), 1'b1);
        if (q0.size() != 0) check("sb0_beat", {out0_last, out0_data}, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        check("sb1_nonempty", (q1.size() != 0), 1'b1);
        if (q1.size() != 0) check("sb1_beat", {out1_last, out1_data}, q1.pop_front());
      end
    end
  end

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    mid_m   = 1'b0;
    route_m = 1'b0;
  end

  task automatic drv(input logic v, input logic [31:0] d, input logic l, input logic s);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic s);
    int k;
    drv(1'b1, d, l, s);
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("send_handshake", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out0_valid", out0_valid, 1'b0);
    check("rst_out1_valid", out1_valid, 1'b0);
    check("rst_out0_data", out0_data, 32'h0);
    check("rst_out0_last", out0_last, 1'b0);
    check("rst_cnt0", cnt0, 16'h0);
    check("rst_cnt1", cnt1, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Packet routing: 3 beats to ch1, in_sel ignored after the first beat.
    step();
    drv(1'b1, 32'h11, 1'b0, 1'b1);
    @(negedge clk);
    check("rt_ready1", in_ready, 1'b1);
    check("rt_busy0", busy, 1'b0);
    step();
    drv(1'b1, 32'h22, 1'b0, 1'b0);
    @(negedge clk);
    check("rt_v1", out1_valid, 1'b1);
    check("rt_d11", out1_data, 32'h11);
    check("rt_l11", out1_last, 1'b0);
    check("rt_busy1", busy, 1'b1);
    check("rt_ch0_idle", out0_valid, 1'b0);
    step();
    drv(1'b1, 32'h33, 1'b1, 1'b0);
    @(negedge clk);
    check("rt_d22", out1_data, 32'h22);
    check("rt_busy2", busy, 1'b1);
    step();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("rt_d33", out1_data, 32'h33);
    check("rt_l33", out1_last, 1'b1);
    check("rt_busy3", busy, 1'b0);
    step();
    @(negedge clk);
    check("rt_drained", out1_valid, 1'b0);
    check("rt_cnt1", cnt1, 16'd3);
    check("rt_cnt0", cnt0, 16'd0);

    // Backpressure: ch0 fills after two beats, third waits for a pop.
    step();
    out0_ready = 1'b0;
    drv(1'b1, 32'hA0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_a0", in_ready, 1'b1);
    step();
    drv(1'b1, 32'hA1, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_ready_a1", in_ready, 1'b1);
    step();
    drv(1'b1, 32'hA2, 1'b1, 1'b1);
    @(negedge clk);
    check("bp_full", in_ready, 1'b0);
    step();
    @(negedge clk);
    check("bp_still_full", in_ready, 1'b0);
    check("bp_hold_a0", out0_data, 32'hA0);
    step();
    out0_ready = 1'b1;
    @(negedge clk);
    check("bp_no_same_cycle_pop", in_ready, 1'b0);
    step();
    out0_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_after_pop", in_ready, 1'b1);
    check("bp_head_a1", out0_data, 32'hA1);
    step();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_busy_done", busy, 1'b0);
    check("bp_head_a1_held", out0_data, 32'hA1);
    check("bp_cnt0", cnt0, 16'd3);

    // Independent drain: ch1 accepts while ch0 is full and stalled.
    step();
    drv(1'b1, 32'h55, 1'b1, 1'b1);
    @(negedge clk);
    check("ind_ready", in_ready, 1'b1);
    step();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("ind_v1", out1_valid, 1'b1);
    check("ind_d55", out1_data, 32'h55);
    check("ind_l55", out1_last, 1'b1);
    check("ind_ch0_head", out0_data, 32'hA1);
    check("ind_ch0_valid", out0_valid, 1'b1);
    step();
    out0_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ind_ch0_empty", out0_valid, 1'b0);

    // Simultaneous push/pop on ch1 holding one beat.
    step();
    out1_ready = 1'b0;
    send(32'h200, 1'b1, 1'b1);
    out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 32'h300 + i, (i == 9), 1'b1);
      @(negedge clk);
      check("pp_ready", in_ready, 1'b1);
      check("pp_valid", out1_valid, 1'b1);
      check("pp_head", out1_data, (i == 0) ? 32'h200 : (32'h300 + i - 1));
      step();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("pp_tail", out1_data, 32'h309);
    check("pp_tail_last", out1_last, 1'b1);
    step();
    @(negedge clk);
    check("pp_empty", out1_valid, 1'b0);

    // Reset mid-packet with ch0 holding two beats.
    step();
    out0_ready = 1'b0;
    send(32'hB0, 1'b0, 1'b0);
    send(32'hB1, 1'b0, 1'b1);
    @(negedge clk);
    check("mr_busy_pre", busy, 1'b1);
    check("mr_v0_pre", out0_valid, 1'b1);
    check("mr_full_pre", in_ready, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_v0", out0_valid, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_cnt0", cnt0, 16'h0);
    check("mr_d0", out0_data, 32'h0);
    step();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(32'hC0, 1'b1, 1'b1);
    @(negedge clk);
    check("mr_v1", out1_valid, 1'b1);
    check("mr_dc0", out1_data, 32'hC0);
    check("mr_v0_post", out0_valid, 1'b0);
    check("mr_cnt1", cnt1, 16'd1);

    // Counter wrap: 65537 single-beat packets to ch0 from a clean reset.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i <= 65536; i++) begin
      drv(1'b1, i, 1'b1, 1'b0);
      if (i == 65536) begin
        @(negedge clk);
        check("wrap_zero", cnt0, 16'h0);
      end
      step();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("wrap_cnt0", cnt0, 16'h1);
    check("wrap_cnt1", cnt1, 16'h0);

    repeat (4) step();
    check("sb0_empty_end", q0.size(), 0);
    check("sb1_empty_end", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
